// File: rtl/redbus_arbiter.sv
// Round-robin Redbus ownership arbiter with a hold quantum, revoke request and forced release.
// Grant, BusRequest, Fault, OwnerId and BusBusy are registered; the shared bus is muxed from the owner.
module redbus_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 8,
    parameter int DEV_WIDTH       = 8,
    parameter int HOLD_CYCLES     = 64,
    parameter int RELEASE_TIMEOUT = 16
) (
    input  logic                              Clock,
    input  logic                              Reset,
    input  logic [NUM_MASTERS-1:0]            Want,
    output logic [NUM_MASTERS-1:0]            Grant,
    output logic [NUM_MASTERS-1:0]            BusRequest,
    input  logic [NUM_MASTERS-1:0]            BusRelease,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] MasterAddress,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] MasterWriteData,
    input  logic [NUM_MASTERS*DEV_WIDTH-1:0]  MasterDevice,
    input  logic [NUM_MASTERS-1:0]            MasterRead,
    input  logic [NUM_MASTERS-1:0]            MasterWrite,
    output logic [ADDR_WIDTH-1:0]             Address,
    output logic [DATA_WIDTH-1:0]             WriteData,
    output logic [DEV_WIDTH-1:0]              RedbusDevice,
    output logic                              Read,
    output logic                              Write,
    input  logic [DATA_WIDTH-1:0]             ReadData,
    output logic [DATA_WIDTH-1:0]             MasterReadData,
    output logic [$clog2(NUM_MASTERS)-1:0]    OwnerId,
    output logic                              BusBusy,
    output logic [NUM_MASTERS-1:0]            Fault
);

    localparam int IDW = $clog2(NUM_MASTERS);
    localparam int HW  = $clog2(HOLD_CYCLES + 1);
    localparam int TW  = $clog2(RELEASE_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, OWNED, REVOKE, HANDOFF} state_t;

    state_t          state;
    logic [IDW-1:0]  last;
    logic [HW-1:0]   hold_cnt;
    logic [TW-1:0]   to_cnt;
    logic [IDW-1:0]  win;
    logic            found;
    logic            others;
    logic            owner_done;

    // Round-robin search starts just after the last owner; reset sets last to N-1 so master 0 leads.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            int unsigned idx;
            idx = 32'(last) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && Want[idx[IDW-1:0]]) begin
                win   = idx[IDW-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        others     = |(Want & ~Grant);
        owner_done = !Want[OwnerId] || BusRelease[OwnerId];
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            Grant      <= '0;
            BusRequest <= '0;
            Fault      <= '0;
            BusBusy    <= 1'b0;
            OwnerId    <= '0;
            last       <= IDW'(NUM_MASTERS - 1);
            hold_cnt   <= '0;
            to_cnt     <= '0;
        end else begin
            Fault <= '0;
            unique case (state)
                IDLE, HANDOFF: begin
                    if (found) begin
                        state      <= OWNED;
                        Grant      <= '0;
                        Grant[win] <= 1'b1;
                        OwnerId    <= win;
                        BusBusy    <= 1'b1;
                        hold_cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                OWNED: begin
                    if (hold_cnt != HW'(HOLD_CYCLES)) hold_cnt <= hold_cnt + 1'b1;
                    if (owner_done) begin
                        state   <= HANDOFF;
                        Grant   <= '0;
                        BusBusy <= 1'b0;
                        last    <= OwnerId;
                    end else if (hold_cnt == HW'(HOLD_CYCLES) && others) begin
                        state               <= REVOKE;
                        BusRequest[OwnerId] <= 1'b1;
                        to_cnt              <= '0;
                    end
                end
                REVOKE: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (owner_done || to_cnt == TW'(RELEASE_TIMEOUT - 1)) begin
                        state      <= HANDOFF;
                        Grant      <= '0;
                        BusRequest <= '0;
                        BusBusy    <= 1'b0;
                        last       <= OwnerId;
                        if (!owner_done) Fault[OwnerId] <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        int unsigned oid;
        oid            = 32'(OwnerId);
        Address        = '0;
        WriteData      = '0;
        RedbusDevice   = '0;
        Read           = 1'b0;
        Write          = 1'b0;
        MasterReadData = ReadData;
        if (BusBusy) begin
            Address      = MasterAddress[oid*ADDR_WIDTH +: ADDR_WIDTH];
            WriteData    = MasterWriteData[oid*DATA_WIDTH +: DATA_WIDTH];
            RedbusDevice = MasterDevice[oid*DEV_WIDTH +: DEV_WIDTH];
            Read         = MasterRead[OwnerId];
            Write        = MasterWrite[OwnerId];
        end
    end

endmodule

// File: tb/tb_redbus_arbiter.sv
// Directed bench for redbus_arbiter: grant, revoke, forced release, rotation, sole owner and reset.
module tb_redbus_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  want, grant, busreq, busrel, mread, mwrite, fault;
    logic [N*AW-1:0] maddr;
    logic [N*DW-1:0] mwdata;
    logic [N*VW-1:0] mdev;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata, mrdata;
    logic [VW-1:0] dev;
    logic          rd, wr, busy;
    logic [1:0]    oid;

    int checks   = 0;
    int failures = 0;

    redbus_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEV_WIDTH(VW),
        .HOLD_CYCLES(8), .RELEASE_TIMEOUT(4)
    ) dut (
        .Clock(clk), .Reset(rst), .Want(want), .Grant(grant), .BusRequest(busreq),
        .BusRelease(busrel), .MasterAddress(maddr), .MasterWriteData(mwdata),
        .MasterDevice(mdev), .MasterRead(mread), .MasterWrite(mwrite),
        .Address(addr), .WriteData(wdata), .RedbusDevice(dev), .Read(rd), .Write(wr),
        .ReadData(rdata), .MasterReadData(mrdata), .OwnerId(oid), .BusBusy(busy),
        .Fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; want = '0; busrel = '0; mread = '0; mwrite = '0; rdata = 8'h5A;
        for (int i = 0; i < N; i++) begin
            maddr[i*AW +: AW]  = 16'h1000 + 16'(i * 16'h111);
            mwdata[i*DW +: DW] = 8'hA0 + 8'(i);
            mdev[i*VW +: VW]   = 8'h10 + 8'(i);
        end
        tick(); tick();
        check("rst_grant", 32'(grant), 0);
        check("rst_busreq", 32'(busreq), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_oid", 32'(oid), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_rdbcast", 32'(mrdata), 32'h5A);

        // first grant after reset goes to the lowest requesting index
        rst = 1'b0; want = 4'b0110; mread = 4'b0001; mwrite = 4'b0010;
        tick();
        check("g1_grant", 32'(grant), 32'b0010);
        check("g1_oid", 32'(oid), 1);
        check("g1_busy", 32'(busy), 1);
        check("g1_addr", 32'(addr), 32'h1111);
        check("g1_wdata", 32'(wdata), 32'hA1);
        check("g1_dev", 32'(dev), 32'h11);
        check("g1_read_nonowner", 32'(rd), 0);
        check("g1_write", 32'(wr), 1);

        // hold quantum: no revoke during the first 8 owned cycles
        want = 4'b1010; mread = '0; mwrite = '0;
        check("hold_busreq0", 32'(busreq), 0);
        for (int c = 1; c < 8; c++) begin
            tick();
            check("hold_busreq", 32'(busreq), 0);
        end
        for (int c = 0; c < 4 && busreq == '0; c++) tick();
        check("revoke_busreq", 32'(busreq), 32'b0010);
        check("revoke_grant", 32'(grant), 32'b0010);
        busrel = 4'b0010;
        tick();
        check("rel_grant0", 32'(grant), 0);
        check("rel_busy0", 32'(busy), 0);
        check("rel_busreq0", 32'(busreq), 0);
        check("rel_fault0", 32'(fault), 0);
        check("rel_addr0", 32'(addr), 0);
        busrel = '0;
        tick();
        check("rel_next_grant", 32'(grant), 32'b1000);
        check("rel_next_oid", 32'(oid), 3);

        // owner 3 ignores the revoke request
        for (int c = 0; c < 12 && busreq == '0; c++) tick();
        check("to_busreq", 32'(busreq), 32'b1000);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("to_nofault", 32'(fault), 0);
            check("to_grant_held", 32'(grant), 32'b1000);
        end
        tick();
        check("to_fault", 32'(fault), 32'b1000);
        check("to_grant0", 32'(grant), 0);
        check("to_busreq0", 32'(busreq), 0);
        tick();
        check("to_fault_pulse", 32'(fault), 0);
        check("to_next_grant", 32'(grant), 32'b0010);

        // reset while master 1 owns the bus
        rst = 1'b1;
        tick();
        check("rstmid_grant", 32'(grant), 0);
        check("rstmid_busreq", 32'(busreq), 0);
        check("rstmid_fault", 32'(fault), 0);

        // full rotation, every owner releases when asked
        rst = 1'b0; want = 4'b1111;
        tick();
        check("rot_grant0", 32'(grant), 32'b0001);
        for (int k = 1; k <= 4; k++) begin
            logic [N-1:0] cur;
            logic [N-1:0] nxt;
            for (int c = 0; c < 15 && busreq == '0; c++) tick();
            check("rot_busreq", 32'(busreq), 32'(grant));
            cur = grant;
            nxt = N'(1) << (k % N);
            busrel = cur;
            tick();
            check("rot_gap", 32'(grant), 0);
            busrel = '0;
            tick();
            check("rot_next", 32'(grant), 32'(nxt));
        end

        // sole requester is never revoked; non-owner releases are ignored
        rst = 1'b1; tick();
        rst = 1'b0; want = 4'b0100; busrel = 4'b1001;
        tick();
        check("sole_grant", 32'(grant), 32'b0100);
        for (int c = 0; c < 100; c++) begin
            tick();
            check("sole_hold", 32'(grant), 32'b0100);
            check("sole_busreq", 32'(busreq), 0);
        end
        rst = 1'b1;
        tick();
        check("sole_rst_grant", 32'(grant), 0);
        check("sole_rst_fault", 32'(fault), 0);
        check("sole_rst_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
